// File: rtl/upsample_pkg.sv
// upsample_pkg: shared types for the 2x upsampler block.
package upsample_pkg;

   typedef logic signed [7:0] pixel_t;

   typedef enum logic {
      EVEN = 1'b0,
      ODD  = 1'b1
   } state_t;

endpackage

// File: rtl/upsample_line_buffer.sv
// upsample_line_buffer: one input row of pixels, written in EVEN rows and
// replayed in ODD rows. Contents are deliberately left without reset.
module upsample_line_buffer
   import upsample_pkg::*;
#(
   parameter int DEPTH = 14,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  pixel_t        wdata,
   input  logic [AW-1:0] raddr,
   output pixel_t        rdata
);

   pixel_t mem_q [DEPTH];

   // single synchronous write port
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/upsample_engine.sv
// upsample_engine: nearest-neighbour 2x upsampler on a raster pixel stream.
// Build option UPSAMPLE_ZERO_FILL_EN switches to max-unpool zero insertion
// (pixel,0 in even rows, all zeros in odd rows) and drops the line buffer.
//
// state | meaning
// EVEN  | accept one input per two outputs, emit each pixel twice, store row
// ODD   | no input accepted, replay stored row with each pixel twice
module upsample_engine
   import upsample_pkg::*;
#(
   parameter int IN_DIM    = 14,
   parameter int OUT_WIDTH = IN_DIM * 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   output logic              ready_in,
   input  logic signed [7:0] pixel_in,
   output logic              valid_out,
   input  logic              ready_out,
   output logic signed [7:0] pixel_out,
   output logic              all_done
);

   localparam int COL_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
   localparam int OC_W  = $clog2(OUT_WIDTH * OUT_WIDTH) + 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_DIM - 1);
   localparam logic [OC_W-1:0]  OC_LAST  = OC_W'(OUT_WIDTH * OUT_WIDTH - 1);

   state_t            state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              phase_q, phase_d;
   logic [COL_W-1:0]  row_q, row_d;
   logic [OC_W-1:0]   out_count_q, out_count_d;
   logic              valid_out_q, valid_out_d;
   pixel_t            pixel_out_q, pixel_out_d;
   logic              all_done_q, all_done_d;
   logic              slot_free;

`ifndef UPSAMPLE_ZERO_FILL_EN
   logic              lb_we;
   pixel_t            lb_rdata;

   upsample_line_buffer #(
      .DEPTH (IN_DIM),
      .AW    (COL_W)
   ) u_line_buffer (
      .clk   (clk),
      .we    (lb_we),
      .waddr (col_q),
      .wdata (pixel_in),
      .raddr (col_q),
      .rdata (lb_rdata)
   );
`endif

   assign slot_free = !valid_out_q || ready_out;
   assign ready_in  = (state_q == EVEN) && !phase_q && slot_free;

   // next-state: row/column walk, output slot load and frame completion
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      phase_d     = phase_q;
      row_d       = row_q;
      out_count_d = out_count_q;
      valid_out_d = valid_out_q;
      pixel_out_d = pixel_out_q;
      all_done_d  = 1'b0;
`ifndef UPSAMPLE_ZERO_FILL_EN
      lb_we       = 1'b0;
`endif

      if (valid_out_q && ready_out) begin
         if (out_count_q == OC_LAST) begin
            out_count_d = '0;
            all_done_d  = 1'b1;
         end else begin
            out_count_d = out_count_q + OC_W'(1);
         end
      end

      case (state_q)
         EVEN: begin
            if (!phase_q) begin
               if (valid_in && ready_in) begin
`ifndef UPSAMPLE_ZERO_FILL_EN
                  lb_we = 1'b1;
`endif
                  pixel_out_d = pixel_in;
                  valid_out_d = 1'b1;
                  phase_d     = 1'b1;
               end else if (slot_free) begin
                  valid_out_d = 1'b0;
               end
            end else if (slot_free) begin
               // second copy of the held pixel (or its zero partner)
`ifdef UPSAMPLE_ZERO_FILL_EN
               pixel_out_d = '0;
`endif
               valid_out_d = 1'b1;
               phase_d     = 1'b0;
               if (col_q == COL_LAST) begin
                  col_d   = '0;
                  state_d = ODD;
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         ODD: begin
            if (slot_free) begin
`ifdef UPSAMPLE_ZERO_FILL_EN
               pixel_out_d = '0;
`else
               pixel_out_d = lb_rdata;
`endif
               valid_out_d = 1'b1;
               phase_d     = !phase_q;
               if (phase_q) begin
                  if (col_q == COL_LAST) begin
                     col_d   = '0;
                     state_d = EVEN;
                     row_d   = (row_q == COL_LAST) ? '0 : row_q + COL_W'(1);
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end
            end
         end
         default: state_d = EVEN;
      endcase
   end

   // state and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EVEN;
         col_q       <= '0;
         phase_q     <= 1'b0;
         row_q       <= '0;
         out_count_q <= '0;
         valid_out_q <= 1'b0;
         pixel_out_q <= '0;
         all_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         phase_q     <= phase_d;
         row_q       <= row_d;
         out_count_q <= out_count_d;
         valid_out_q <= valid_out_d;
         pixel_out_q <= pixel_out_d;
         all_done_q  <= all_done_d;
      end
   end

   assign valid_out = valid_out_q;
   assign pixel_out = pixel_out_q;
   assign all_done  = all_done_q;

endmodule

// File: doc/upsample_engine.md
# upsample_engine

Nearest-neighbour 2x upsampler. It is the inverse counterpart of the 2x2/stride-2 max-pool stage. It consumes a raster-order IN_DIM x IN_DIM stream of signed 8-bit pixels and emits an OUT_WIDTH x OUT_WIDTH raster stream, with each input pixel replicated into a 2x2 block. It sits on the decoder/expansion path between feature-map producers and consumers, and uses valid/ready on both sides because output rate is 4x input rate.

## Interface
- IN_DIM, default 14: input map width and height.
- OUT_WIDTH, default IN_DIM*2: output map width and height (fixed to 2*IN_DIM).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- valid_in  in  1  input pixel valid.
- ready_in  out  1  input pixel accepted when valid_in && ready_in.
- pixel_in  in  8  signed input pixel.
- valid_out  out  1  output pixel valid.
- ready_out  in  1  downstream accepts when valid_out && ready_out.
- pixel_out  out  8  signed output pixel.
- all_done  out  1  one-cycle pulse after the final output pixel of a frame is accepted.

## Operation
- Output register slot: slot_free = !valid_out || ready_out. Output state changes only when slot_free is high.
- State machine states:
  - EVEN: emit input row twice per pixel; store in line buffer.
  - ODD: replay line buffer.
- Internal counters:
  - col: 0..IN_DIM-1.
  - phase: 0/1, duplicate index.
  - row: 0..IN_DIM-1.
  - out_count: width $clog2(OUT_WIDTH*OUT_WIDTH)+1.
- ready_in = (state==EVEN) && phase==0 && slot_free. This is combinational from ready_out.
- EVEN, phase 0, on input handshake: linebuf[col] <= pixel_in; pixel_out <= pixel_in; valid_out <= 1; phase <= 1.
- EVEN, phase 1, slot_free: re-present the held pixel (valid_out <= 1, pixel_out unchanged); phase <= 0.
  - If col==IN_DIM-1: col <= 0, state <= ODD.
  - Else: col <= col+1.
- ODD, slot_free: pixel_out <= linebuf[col]; valid_out <= 1; phase toggles. After phase 1:
  - If col==IN_DIM-1: col <= 0, state <= EVEN, and row increments, wrapping to 0 after IN_DIM-1.
  - Else: col++.
- No new output available and slot_free: valid_out <= 0.
- out_count increments on each output handshake. On the handshake with out_count==OUT_WIDTH*OUT_WIDTH-1: out_count <= 0 and all_done <= 1 for exactly one cycle.
- Arithmetic: pixels pass through bit-exact. No sign extension or saturation.

## Timing
- Reset values: valid_out=0, pixel_out=0, all_done=0, ready_in follows the reset state.
- Reset state: EVEN, col=0, phase=0, row=0, out_count=0. The line buffer is not cleared.
- Latency: a pixel accepted at edge N appears on pixel_out in the cycle after N.
- Throughput with ready_out held high: one output per cycle. Input is accepted every second cycle during EVEN rows and never during ODD rows.
- Backpressure: while valid_out && !ready_out, pixel_out and valid_out hold stable, with no skip or duplicate.
- Upstream must hold valid_in/pixel_in until accepted.
- Frame wrap: after the final ODD-row pixel, the state returns to EVEN row 0. The next frame's first pixel may be accepted in the same cycle that all_done is high.
- rst mid-frame: all counters and the state are cleared on the next edge, valid_out is 0, and the partial frame is discarded. No all_done is generated for it.

## Configuration
- UPSAMPLE_ZERO_FILL_EN defined: max-unpool zero insertion.
  - EVEN rows emit pixel, 0 per input.
  - ODD rows emit all zeros (OUT_WIDTH pixels).
  - The line buffer is not instantiated.
  - Handshake, latency and all_done behaviour are unchanged.
- Undefined: nearest-neighbour replication as described above.

## Structure
- Shared package upsample_pkg:
  - pixel_t (logic signed [7:0]).
  - State enum (EVEN, ODD).
- Sub-module upsample_line_buffer: IN_DIM x pixel_t register array, one synchronous write port, one combinational read port, no reset on contents.
- The top module holds the FSM, counters and output register.

## Test plan
- IN_DIM=2, input 1,2,3,4, ready_out=1 → output 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4. all_done pulses one cycle after the 16th handshake.
- Values -128, 127, -1, 0 (IN_DIM=2) → each reproduced bit-exact in its 2x2 block.
- ready_out low for 3 cycles between the two copies of pixel 2 → pixel_out stays 2 with valid_out high, and the sequence is otherwise unchanged.
- valid_in held high throughout → ready_in low for the entire ODD row (2*IN_DIM output handshakes). No input is consumed there.
- rst asserted after 3 input pixels, then a fresh 1,2,3,4 frame → valid_out 0 the cycle after rst, then the exact sequence from scenario 1.
- UPSAMPLE_ZERO_FILL_EN defined, input 1,2,3,4 → 1,0,2,0,0,0,0,0,3,0,4,0,0,0,0,0. all_done pulses as in scenario 1. Two back-to-back frames produce two pulses.
